// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage: widths, reset level,
// NOP encoding, fetch FSM state encoding and the sequential PC increment.
package if_stage_pkg;

    localparam int unsigned INST_W = 32;
    localparam logic RST_ACTIVE = 1'b1;
    localparam logic [INST_W-1:0] NOP_INST = '0;  // sll $0,$0,0

    // Fetch FSM states
    localparam logic [1:0] StFetch   = 2'd0;
    localparam logic [1:0] StHold    = 2'd1;
    localparam logic [1:0] StDiscard = 2'd2;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Bubble beats stall beats load; a non-stalled cycle
// without a load writes a bubble so the decoder never sees a stale word twice.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter int unsigned INST_WIDTH = INST_W,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  load,
    input  logic                  bubble,
    input  logic [INST_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic [INST_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_valid
);

    // IF/ID contents: flush first, then hold on stall, else load or bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ACTIVE) begin
            inst       <= INST_WIDTH'(NOP_INST);
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else if (bubble) begin
            inst       <= INST_WIDTH'(NOP_INST);
            inst_valid <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                inst       <= data;
                inst_pc    <= pc;
                inst_valid <= 1'b1;
            end else begin
                inst       <= INST_WIDTH'(NOP_INST);
                inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one imem read at a time and
// feeds the IF/ID register. Optional macro BRANCH_DELAY_SLOT_EN keeps the
// instruction at the current pc (delay slot) alive across a redirect.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned           INST_WIDTH = INST_W,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic [INST_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_valid
);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pend_q, pend_d;
    logic [INST_WIDTH-1:0] skid_q, skid_d;
    logic                  req_en_q;
`ifdef BRANCH_DELAY_SLOT_EN
    logic                  rp_q, rp_d;
    logic [ADDR_WIDTH-1:0] seq_pc;
`endif

    logic                  ack;
    logic                  stall_eff;
    logic                  load;
    logic                  bubble;
    logic [INST_WIDTH-1:0] ld_data;
    logic [ADDR_WIDTH-1:0] pc_inc;

    // Request is held off for one cycle after reset so it rises cleanly
    assign imem_req  = req_en_q & (state_q != StHold);
    assign imem_addr = pc_q;
    assign ack       = imem_ack & imem_req;
    assign stall_eff = stall & ~redirect_valid;  // a redirect always wins over stall
    assign pc_inc    = pc_q + ADDR_WIDTH'(PC_INC);
`ifdef BRANCH_DELAY_SLOT_EN
    assign seq_pc = redirect_valid ? redirect_pc : (rp_q ? pend_q : pc_inc);
`endif

    // Next-state, PC and IF/ID control
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        skid_d  = skid_q;
        load    = 1'b0;
        bubble  = 1'b0;
        ld_data = imem_rdata;
`ifdef BRANCH_DELAY_SLOT_EN
        rp_d    = rp_q;
        case (state_q)
            StHold: begin
                if (!stall_eff) begin
                    load    = 1'b1;
                    ld_data = skid_q;
                    pc_d    = seq_pc;
                    rp_d    = 1'b0;
                    state_d = StFetch;
                end
            end
            default: begin
                if (ack && stall_eff) begin
                    skid_d  = imem_rdata;
                    state_d = StHold;
                end else if (ack) begin
                    load = 1'b1;
                    pc_d = seq_pc;
                    rp_d = 1'b0;
                end else if (redirect_valid) begin
                    // Slot still in flight: remember target until it lands
                    pend_d = redirect_pc;
                    rp_d   = 1'b1;
                end
            end
        endcase
`else
        case (state_q)
            StHold: begin
                if (redirect_valid) begin
                    bubble  = 1'b1;
                    pc_d    = redirect_pc;
                    state_d = StFetch;
                end else if (!stall) begin
                    load    = 1'b1;
                    ld_data = skid_q;
                    pc_d    = pc_inc;
                    state_d = StFetch;
                end
            end
            StDiscard: begin
                // imem_addr stays on the abandoned pc until its ack drains
                if (redirect_valid) begin
                    bubble = 1'b1;
                    pend_d = redirect_pc;
                end
                if (ack) begin
                    pc_d    = redirect_valid ? redirect_pc : pend_q;
                    state_d = StFetch;
                end
            end
            default: begin
                if (redirect_valid) begin
                    bubble = 1'b1;
                    if (ack) begin
                        pc_d = redirect_pc;
                    end else begin
                        pend_d  = redirect_pc;
                        state_d = StDiscard;
                    end
                end else if (ack) begin
                    if (stall) begin
                        skid_d  = imem_rdata;
                        state_d = StHold;
                    end else begin
                        load = 1'b1;
                        pc_d = pc_inc;
                    end
                end
            end
        endcase
`endif
    end

    // Fetch state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ACTIVE) begin
            state_q  <= StFetch;
            pc_q     <= RESET_PC;
            pend_q   <= '0;
            skid_q   <= '0;
            req_en_q <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
            rp_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pend_q   <= pend_d;
            skid_q   <= skid_d;
            req_en_q <= 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
            rp_q     <= rp_d;
`endif
        end
    end

    if_id_reg #(
        .INST_WIDTH(INST_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall_eff),
        .load      (load),
        .bubble    (bubble),
        .data      (ld_data),
        .pc        (pc_q),
        .inst      (inst),
        .inst_pc   (inst_pc),
        .inst_valid(inst_valid)
    );

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the ID-stage decoder.
- Owns the PC and issues one instruction-memory read at a time over a req/ack handshake.
- Presents the fetched word to the decoder, which decodes `inst` combinationally.
- Handles stalls from the hazard unit and PC redirects (branch/jump) from the ID stage.

Parameters:
- INST_WIDTH, 32, instruction word width (equals the shared instruction-width constant).
- ADDR_WIDTH, 32, PC/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and IF/ID contents.
- redirect_valid  in  1  load redirect_pc as the next fetch PC.
- redirect_pc  in  ADDR_WIDTH  branch/jump target; word aligned.
- imem_req  out  1  read request.
- imem_addr  out  ADDR_WIDTH  read address.
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  INST_WIDTH  read data.
- inst  out  INST_WIDTH  IF/ID instruction to decoder; 0 (NOP, sll $0,$0,0) when invalid.
- inst_pc  out  ADDR_WIDTH  PC of `inst`.
- inst_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async) values:
  - pc=RESET_PC, state=FETCH, imem_req=0.
  - inst=0, inst_pc=0, inst_valid=0.
  - skid buffer empty; pend_pc=0.
- imem_req rises the first cycle after rst deasserts.
- Handshake:
  - imem_addr stays stable while imem_req=1 until imem_ack.
  - One outstanding request at most.
  - Ack latency is ≥1 cycle after req first seen.
  - Ack without an outstanding req is illegal (bench assertion).
- FETCH (imem_req=1, imem_addr=pc):
  - ack & ~stall: IF/ID <= {imem_rdata, pc, 1}; pc <= pc+4; stay FETCH. Back-to-back issue next cycle.
  - ack & stall: capture imem_rdata into skid buffer; IF/ID unchanged; go HOLD.
  - ~ack & ~stall: IF/ID <= bubble (inst=0, valid=0).
  - ~ack & stall: IF/ID unchanged.
- HOLD (imem_req=0):
  - ~stall: IF/ID <= {buffer, pc, 1}; pc <= pc+4; go FETCH.
  - stall: remain in HOLD.
- DISCARD (imem_req=1, imem_addr = old pc, held):
  - IF/ID <= bubble each non-stalled cycle.
  - ack: drop the data; pc <= pend_pc; go FETCH.
- Redirect (highest priority; overrides stall):
  - Branch occupies IF/ID this cycle and proceeds, so "flush" means the value written into IF/ID this cycle is a bubble.
  - FETCH & ack: drop data; pc <= redirect_pc; stay FETCH.
  - FETCH & ~ack: pend_pc <= redirect_pc; go DISCARD.
  - HOLD: drop buffer; pc <= redirect_pc; go FETCH.
  - DISCARD: pend_pc <= redirect_pc (latest wins); stay DISCARD.
- redirect_valid & stall together is illegal from the hazard unit. If it occurs, redirect wins (bench assertion).
- PC arithmetic: modulo 2^ADDR_WIDTH; 32'hFFFF_FFFC + 4 wraps to 0.
- rst asserted mid-request: immediate return to reset values. The outstanding request is abandoned; the memory model must drop it on rst.

Optional Feature:
- Macro: BRANCH_DELAY_SLOT_EN.
- Defined: a redirect does not bubble the instruction at the current pc (the delay slot).
  - FETCH & ack: slot enters IF/ID normally; pc <= redirect_pc.
  - FETCH & ~ack: pend_pc <= redirect_pc; stay FETCH. When the slot's ack arrives, deliver it normally, then pc <= pend_pc. Uses a redirect_pending flag; no DISCARD.
  - HOLD: buffered slot delivered on ~stall; pc <= redirect_pc afterwards.
- Undefined: behaviour exactly as in Behaviour above.

Decomposition:
- Shared package/defines file holds:
  - instruction width; reset-enable level; NOP encoding (0).
  - if_stage state encoding (FETCH, HOLD, DISCARD).
  - PC increment constant (4).
- Sub-module if_id_reg holds the IF/ID register.
  - Inputs: load, bubble, data/pc; honours stall.
  - Async reset.
  - Keeps the flush/stall priority in one place.

Test Plan:
- Reset then 1-cycle-ack memory holding 0x20010005 at addr 0: inst_valid=1, inst=0x20010005, inst_pc=0 two cycles after rst deasserts. imem_addr then 4, 8, 12 on consecutive acks.
- 3-cycle ack latency:
  - inst_valid=0 with inst=0 for 2 cycles between valid instructions.
  - imem_addr held constant across each request.
- stall=1 coincident with ack of 0x00221820 at pc=8:
  - HOLD, imem_req=0, IF/ID unchanged.
  - stall=0 → inst=0x00221820, inst_pc=8 next cycle; fetch resumes at 12.
- redirect_pc=0x40 during an un-acked fetch of pc=0x10:
  - DISCARD; imem_addr stays 0x10.
  - Its data never reaches inst; the next fetch address is 0x40.
- redirect_pc=0x80 in the same cycle as ack of pc=0x14:
  - undefined macro: IF/ID bubble; next imem_addr=0x80.
  - BRANCH_DELAY_SLOT_EN: inst_pc=0x14 valid; next imem_addr=0x80.
- pc=32'hFFFF_FFFC fetched then ack → next imem_addr=0. rst pulsed mid-request → outputs back to reset values asynchronously.
